// File: rtl/fec_job_ctrl.sv
`default_nettype none
// ============================================================================
// fec_job_ctrl : host-side job sequencer for the FEC core
//                (load message, start core, wait for done, stream results).
// Revision     : 1.0
// ============================================================================
module fec_job_ctrl #(
  parameter int          AW           = 8,
  parameter int          LOAD_N       = 30,
  parameter int          LOAD_BASE    = 0,
  parameter int          RESULT_N     = 30,
  parameter int          RESULT_BASE  = 30,
  parameter int          START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          proc_start,
  input  logic          proc_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          busy,
  output logic          timeout_err,
  output logic [15:0]   run_cycles
);

  // Byte counter is one bit wider than the address so a full 2^AW job fits.
  localparam int CW = AW + 1;
  localparam int SW = $clog2(START_CYCLES + 1);

  localparam logic [AW-1:0] c_load_base   = AW'(LOAD_BASE);
  localparam logic [AW-1:0] c_result_base = AW'(RESULT_BASE);
  localparam logic [CW-1:0] c_load_last   = CW'(LOAD_N - 1);
  localparam logic [CW-1:0] c_result_last = CW'(RESULT_N - 1);
  localparam logic [SW-1:0] c_start_last  = SW'(START_CYCLES - 1);
  localparam logic [15:0]   c_to_last     = TIMEOUT - 16'd1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_OUT     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [15:0]   run_q, run_d;
  logic          terr_q, terr_d;
  logic [7:0]    odata_q, odata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      run_q   <= '0;
      terr_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      run_q   <= run_d;
      terr_q  <= terr_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    run_d     = run_q;
    terr_d    = terr_q;
    odata_d   = odata_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          terr_d  = 1'b0;
          run_d   = '0;
          addr_d  = c_load_base;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = in_data;
          addr_d    = addr_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == c_load_last) begin
            scnt_d  = '0;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == c_start_last) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Done takes priority over a timeout landing on the same cycle.
        if (proc_done) begin
          addr_d  = c_result_base;
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          if (run_q != 16'hFFFF) begin
            run_d = run_q + 16'd1;
          end
          if (run_q == c_to_last) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_RD_REQ: begin
        mem_re   = 1'b1;
        mem_addr = addr_q;
        state_d  = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        odata_d = mem_rdata;
        state_d = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == c_result_last) ? S_IDLE : S_RD_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign job_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_LOAD);
  assign proc_start  = (state_q == S_START);
  assign out_valid   = (state_q == S_OUT);
  assign out_data    = odata_q;
  assign timeout_err = terr_q;
  assign run_cycles  = run_q;

endmodule
`default_nettype wire

// File: tb/tb_fec_job_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fec_job_ctrl : directed + randomized job sequences checked against a
//                   transaction-level model of the job controller.
// Revision        : 1.0
// ============================================================================
module tb_fec_job_ctrl;

  localparam int AW   = 8;
  localparam int LN   = 4;
  localparam int RN   = 4;
  localparam int RB   = 30;
  localparam int SC   = 2;
  localparam int TO   = 16;
  localparam int LB_A = 254;
  localparam int LB_B = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic job_valid = 1'b0;
  logic in_valid = 1'b0;
  logic proc_done = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic a_job_ready, a_in_ready, a_mem_we, a_mem_re, a_proc_start;
  logic a_out_valid, a_busy, a_timeout_err;
  logic [7:0] a_mem_addr, a_mem_wdata, a_out_data, a_rdata;
  logic [15:0] a_run_cycles;

  logic b_job_ready, b_in_ready, b_mem_we, b_mem_re, b_proc_start;
  logic b_out_valid, b_busy, b_timeout_err;
  logic [7:0] b_mem_addr, b_mem_wdata, b_out_data, b_rdata;
  logic [15:0] b_run_cycles;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        a_wq[$];
  wr_t        b_wq[$];
  logic [7:0] rq[$];
  logic [7:0] a_oq[$];
  logic [7:0] b_oq[$];
  int         sq[$];
  logic       ovq[$];
  logic [7:0] res_mem [256];
  logic       prev_stall;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  // Instance A exercises address wrap; instance B loads from address 0.
  fec_job_ctrl #(
    .AW(AW), .LOAD_N(LN), .LOAD_BASE(LB_A), .RESULT_N(RN), .RESULT_BASE(RB),
    .START_CYCLES(SC), .TIMEOUT(16'(TO))
  ) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(a_job_ready),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_rdata),
    .proc_start(a_proc_start), .proc_done(proc_done),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .busy(a_busy), .timeout_err(a_timeout_err), .run_cycles(a_run_cycles)
  );

  fec_job_ctrl #(
    .AW(AW), .LOAD_N(LN), .LOAD_BASE(LB_B), .RESULT_N(RN), .RESULT_BASE(RB),
    .START_CYCLES(SC), .TIMEOUT(16'(TO))
  ) dut_b (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(b_job_ready),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata),
    .proc_start(b_proc_start), .proc_done(proc_done),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .busy(b_busy), .timeout_err(b_timeout_err), .run_cycles(b_run_cycles)
  );

  // Result memory: one-cycle read latency.
  always @(posedge clk) begin
    if (a_mem_re) a_rdata <= res_mem[a_mem_addr];
    if (b_mem_re) b_rdata <= res_mem[b_mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    a_wq.delete();
    b_wq.delete();
    rq.delete();
    a_oq.delete();
    b_oq.delete();
    sq.delete();
    ovq.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags_a"}, 64'({a_job_ready, a_busy, a_in_ready, a_mem_we, a_mem_re,
                               a_proc_start, a_out_valid, a_timeout_err}), 64'(8'h80));
    chk({tag, "_data_a"}, 64'({a_mem_addr, a_mem_wdata, a_out_data, a_run_cycles}), 64'(0));
    chk({tag, "_flags_b"}, 64'({b_job_ready, b_busy, b_in_ready, b_mem_we, b_mem_re,
                               b_proc_start, b_out_valid, b_timeout_err}), 64'(8'h80));
    chk({tag, "_data_b"}, 64'({b_mem_addr, b_mem_wdata, b_out_data, b_run_cycles}), 64'(0));
  endtask

  // Event log and cycle-level protocol rules.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall <= 1'b0;
    end else begin
      chk("we_re_exclusive", 64'(a_mem_we & a_mem_re), 64'(0));
      chk("we_needs_valid", 64'(a_mem_we & ~in_valid), 64'(0));
      if (prev_stall) begin
        chk("stall_hold", 64'({a_out_valid, a_mem_re, a_out_data}),
            64'({1'b1, 1'b0, prev_data}));
      end
      if (a_mem_we) a_wq.push_back(wr_t'({a_mem_addr, a_mem_wdata}));
      if (b_mem_we) b_wq.push_back(wr_t'({b_mem_addr, b_mem_wdata}));
      if (a_mem_re) rq.push_back(a_mem_addr);
      if (a_proc_start) sq.push_back(a_wq.size());
      if (a_out_valid) ovq.push_back(1'b1);
      if (a_out_valid && out_ready) a_oq.push_back(a_out_data);
      if (b_out_valid && out_ready) b_oq.push_back(b_out_data);
      prev_stall <= a_out_valid & ~out_ready;
      prev_data  <= a_out_data;
    end
  end

  // One complete job. gap<0 selects the fixed 1,0,0,1,... in_valid pattern.
  task automatic run_job(input int d, input int s_lo, input int s_hi, input int gap,
                         input bit hold_jv, input bit expect_to, input bit fixed);
    logic [7:0] msg [LN];
    int i, guard, cyc, acc, stall, s_lim, exp_run;
    bit hs;
    clear_logs();
    for (int k = 0; k < LN; k++) begin
      msg[k] = fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom);
      res_mem[RB + k] = fixed ? 8'(8'hA0 + k) : 8'($urandom);
    end

    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    chk("accept", 64'({a_busy, a_job_ready, a_in_ready}), 64'(3'b101));
    chk("accept_clears", 64'({a_timeout_err, a_run_cycles}), 64'(0));

    i = 0; guard = 0; cyc = 0;
    while (i < LN && guard < 200) begin
      in_valid = (gap < 0) ? (cyc % 3 == 0) : ($urandom_range(99, 0) >= 32'(gap));
      in_data  = msg[i];
      chk("no_early_start", 64'(a_proc_start), 64'(0));
      @(negedge clk);
      hs = in_valid & a_in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++; guard++;
    end
    in_valid = 1'b0;
    chk("load_complete", 64'(i), 64'(LN));

    guard = 0;
    while (!a_proc_start && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("start_seen", 64'(a_proc_start), 64'(1));
    while (a_proc_start && guard < 40) begin @(posedge clk); #1; guard++; end
    chk("run_entered", 64'({a_busy, a_proc_start}), 64'(2'b10));

    if (expect_to) begin
      guard = 0;
      while (!a_job_ready && guard < 100) begin @(posedge clk); #1; guard++; end
      chk("timeout_idle", 64'(a_job_ready), 64'(1));
    end else begin
      if (hold_jv) job_valid = 1'b1;
      repeat (d) @(posedge clk);
      #1;
      if (hold_jv) chk("jv_ignored_in_run", 64'({a_busy, a_job_ready}), 64'(2'b10));
      job_valid = 1'b0;
      proc_done = 1'b1;
      @(posedge clk); #1;
      proc_done = 1'b0;

      acc = 0; stall = 0; guard = 0;
      s_lim = int'($urandom_range(s_hi, s_lo));
      while (acc < RN && guard < 400) begin
        out_ready = a_out_valid && (stall >= s_lim);
        if (a_out_valid && !out_ready) stall++;
        hs = out_ready;
        @(posedge clk); #1;
        guard++;
        if (hs) begin
          acc++;
          stall = 0;
          s_lim = int'($urandom_range(s_hi, s_lo));
        end
      end
      out_ready = 1'b0;
      chk("out_complete", 64'(acc), 64'(RN));
      chk("end_idle", 64'({a_job_ready, a_busy}), 64'(2'b10));
    end

    chk("wr_count_a", 64'(a_wq.size()), 64'(LN));
    chk("wr_count_b", 64'(b_wq.size()), 64'(LN));
    for (int k = 0; k < LN && k < a_wq.size(); k++)
      chk("wr_a", 64'({a_wq[k].a, a_wq[k].d}), 64'({8'((LB_A + k) % 256), msg[k]}));
    for (int k = 0; k < LN && k < b_wq.size(); k++)
      chk("wr_b", 64'({b_wq[k].a, b_wq[k].d}), 64'({8'((LB_B + k) % 256), msg[k]}));
    chk("start_len", 64'(sq.size()), 64'(SC));
    if (sq.size() > 0) chk("writes_before_start", 64'(sq[0]), 64'(LN));

    exp_run = expect_to ? TO : d;
    chk("status_a", 64'({a_timeout_err, a_run_cycles}), 64'({expect_to, 16'(exp_run)}));
    chk("status_b", 64'({b_timeout_err, b_run_cycles}), 64'({expect_to, 16'(exp_run)}));

    if (expect_to) begin
      chk("timeout_no_readback", 64'(rq.size() + ovq.size()), 64'(0));
    end else begin
      chk("rd_count", 64'(rq.size()), 64'(RN));
      chk("out_count", 64'({a_oq.size(), b_oq.size()}), 64'({RN, RN}));
      for (int k = 0; k < RN && k < rq.size(); k++)
        chk("rd_addr", 64'(rq[k]), 64'(RB + k));
      for (int k = 0; k < RN && k < a_oq.size(); k++)
        chk("out_a", 64'(a_oq[k]), 64'(res_mem[RB + k]));
      for (int k = 0; k < RN && k < b_oq.size(); k++)
        chk("out_b", 64'(b_oq[k]), 64'(res_mem[RB + k]));
    end
  endtask

  task automatic reset_mid_load();
    clear_logs();
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 8'(8'hC0 + k);
      @(posedge clk); #1;
    end
    in_data = 8'hC2;
    #2 reset = 1'b0;
    #1 chk_reset("reset_mid_load");
    chk("wr_before_reset", 64'({a_wq.size(), b_wq.size()}), 64'({32'd2, 32'd2}));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk_reset("after_release");
  endtask

  initial begin
    for (int k = 0; k < 256; k++) res_mem[k] = 8'(k ^ 8'h5C);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    @(posedge clk); #1;

    run_job(10, 0, 0, 0,  1'b0, 1'b0, 1'b1);   // basic job, fixed data
    run_job(6,  0, 0, -1, 1'b0, 1'b0, 1'b0);   // input gaps 1,0,0,1,...
    run_job(3,  5, 5, 0,  1'b0, 1'b0, 1'b0);   // 5-cycle output stalls
    run_job(0,  0, 0, 0,  1'b0, 1'b1, 1'b0);   // timeout, no done
    run_job(4,  1, 2, 20, 1'b0, 1'b0, 1'b0);   // next job clears timeout_err
    reset_mid_load();
    run_job(5,  0, 1, 0,  1'b0, 1'b0, 1'b0);   // fresh job restarts at base
    run_job(9,  0, 2, 0,  1'b1, 1'b0, 1'b0);   // job_valid held during RUN
    run_job(15, 0, 0, 0,  1'b0, 1'b0, 1'b0);   // done on the timeout cycle
    run_job(0,  0, 0, 0,  1'b0, 1'b0, 1'b0);   // done on first RUN cycle
    for (int n = 0; n < 8; n++) begin
      run_job(int'($urandom_range(14, 0)), 0, int'($urandom_range(4, 0)),
              int'($urandom_range(60, 0)), 1'($urandom_range(1, 0)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
